stage5_field_extract: RTL and testbench

Parametrised, flow-controlled successor to the stage-5 single-field extractors. Sits between the message-classification stage and stage 6: for each of `CHANNELS` independent message lanes it picks one field from the message word according to the lane's mux-control type, substitutes the default value when disabled or unmatched, and queues the result in a 2-entry per-lane FIFO. Unlike the combinational extractors, it supports two message layouts, per-lane valid/ready backpressure and an extraction-hit flag.

---
 rtl/stage5_field_extract_pkg.sv | 24 ++
 rtl/stage5_field_lane.sv | 114 +++++++++++
 rtl/stage5_field_extract.sv | 56 +++++
 tb/tb_stage5_field_extract.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stage5_field_extract_pkg.sv
// Shared widths, bit positions, type codes and default value for the
// stage-5 field extractor (optional statistics: STAGE5_FIELD_STATS_EN).
package stage5_field_extract_pkg;

    localparam int MAX_MESSAGE_BITS          = 128;
    localparam int FIELD_V4_BITS             = 32;
    localparam int MESSAGE_MUX_CONTROL_WIDTH = 2;

    localparam int A_V4_B = 95;
    localparam int A_V4_E = 64;
    localparam int B_V4_E = 0;

    localparam logic [FIELD_V4_BITS-1:0] DEFAUT_INFOR = 32'hDEAD_BEEF;

    typedef enum logic [MESSAGE_MUX_CONTROL_WIDTH-1:0] {
        MUX_NONE = 2'd0,
        MUX_A    = 2'd1,
        MUX_B    = 2'd2,
        MUX_RSVD = 2'd3
    } mux_type_e;

    localparam int STAT_W = 16;

endpackage

// File: rtl/stage5_field_lane.sv
// One lane: field extract mux, 2-entry FIFO, optional pop statistics
// (enabled by STAGE5_FIELD_STATS_EN).
module stage5_field_lane
    import stage5_field_extract_pkg::*;
#(
    parameter int                 MSG_W       = MAX_MESSAGE_BITS,
    parameter int                 FIELD_W     = FIELD_V4_BITS,
    parameter int                 CTRL_W      = MESSAGE_MUX_CONTROL_WIDTH,
    parameter int                 A_LSB       = A_V4_E,
    parameter int                 B_LSB       = B_V4_E,
    parameter logic [FIELD_W-1:0] DEFAULT_VAL = DEFAUT_INFOR
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               message_en,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [MSG_W-1:0]   message,
    input  logic [CTRL_W-1:0]  ctrl,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [FIELD_W-1:0] out_field,
    output logic               out_hit,
    input  logic               stats_clr,
    output logic [STAT_W-1:0]  stat_hits,
    output logic [STAT_W-1:0]  stat_miss
);

    localparam int E_W = FIELD_W + 1;

    logic [E_W-1:0] r_mem [2];
    logic           r_wptr;
    logic           r_rptr;
    logic [1:0]     r_cnt;

    logic           w_push;
    logic           w_pop;
    logic [E_W-1:0] w_entry;
    logic [E_W-1:0] w_head;
    logic           w_unused;

    always_comb begin
        w_entry = {1'b0, DEFAULT_VAL};
        if (message_en) begin
            if (ctrl == CTRL_W'(MUX_A))
                w_entry = {1'b1, message[A_LSB +: FIELD_W]};
            else if (ctrl == CTRL_W'(MUX_B))
                w_entry = {1'b1, message[B_LSB +: FIELD_W]};
        end
    end

    assign in_ready  = (r_cnt != 2'd2);
    assign out_valid = (r_cnt != 2'd0);
    assign w_push    = in_valid && in_ready;
    assign w_pop     = out_valid && out_ready;
    assign w_head    = r_mem[r_rptr];
    assign out_field = out_valid ? w_head[FIELD_W-1:0] : DEFAULT_VAL;
    assign out_hit   = out_valid && w_head[FIELD_W];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wptr   <= 1'b0;
            r_rptr   <= 1'b0;
            r_cnt    <= 2'd0;
        end else begin
            if (w_push) begin
                r_mem[r_wptr] <= w_entry;
                r_wptr        <= ~r_wptr;
            end
            if (w_pop)
                r_rptr <= ~r_rptr;
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + 2'd1;
                2'b01:   r_cnt <= r_cnt - 2'd1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    // Only the two field windows of the message are consumed.
    assign w_unused = ^{message, stats_clr};

`ifdef STAGE5_FIELD_STATS_EN
    logic [STAT_W-1:0] r_hits;
    logic [STAT_W-1:0] r_miss;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hits <= '0;
            r_miss <= '0;
        end else if (stats_clr) begin
            r_hits <= '0;
            r_miss <= '0;
        end else if (w_pop) begin
            if (out_hit) begin
                if (r_hits != '1)
                    r_hits <= r_hits + 1'b1;
            end else begin
                if (r_miss != '1)
                    r_miss <= r_miss + 1'b1;
            end
        end
    end

    assign stat_hits = r_hits;
    assign stat_miss = r_miss;
`else
    assign stat_hits = '0;
    assign stat_miss = '0;
`endif

endmodule

// File: rtl/stage5_field_extract.sv
// Per-lane flow-controlled field extractor between classification and
// stage 6 (optional statistics: STAGE5_FIELD_STATS_EN).
module stage5_field_extract
    import stage5_field_extract_pkg::*;
#(
    parameter int                 CHANNELS    = 3,
    parameter int                 MSG_W       = MAX_MESSAGE_BITS,
    parameter int                 FIELD_W     = FIELD_V4_BITS,
    parameter int                 CTRL_W      = MESSAGE_MUX_CONTROL_WIDTH,
    parameter int                 A_LSB       = A_V4_E,
    parameter int                 B_LSB       = B_V4_E,
    parameter logic [FIELD_W-1:0] DEFAULT_VAL = DEFAUT_INFOR
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          message_en,
    input  logic [CHANNELS-1:0]           in_valid,
    output logic [CHANNELS-1:0]           in_ready,
    input  logic [CHANNELS*MSG_W-1:0]     message,
    input  logic [CHANNELS*CTRL_W-1:0]    message_mux_control,
    output logic [CHANNELS-1:0]           out_valid,
    input  logic [CHANNELS-1:0]           out_ready,
    output logic [CHANNELS*FIELD_W-1:0]   out_field,
    output logic [CHANNELS-1:0]           out_hit,
    input  logic                          stats_clr,
    output logic [CHANNELS*STAT_W-1:0]    stat_hits,
    output logic [CHANNELS*STAT_W-1:0]    stat_miss
);

    for (genvar g = 0; g < CHANNELS; g++) begin : g_lane
        stage5_field_lane #(
            .MSG_W       (MSG_W),
            .FIELD_W     (FIELD_W),
            .CTRL_W      (CTRL_W),
            .A_LSB       (A_LSB),
            .B_LSB       (B_LSB),
            .DEFAULT_VAL (DEFAULT_VAL)
        ) u_lane (
            .clk        (clk),
            .rst_n      (rst_n),
            .message_en (message_en),
            .in_valid   (in_valid[g]),
            .in_ready   (in_ready[g]),
            .message    (message[g*MSG_W +: MSG_W]),
            .ctrl       (message_mux_control[g*CTRL_W +: CTRL_W]),
            .out_valid  (out_valid[g]),
            .out_ready  (out_ready[g]),
            .out_field  (out_field[g*FIELD_W +: FIELD_W]),
            .out_hit    (out_hit[g]),
            .stats_clr  (stats_clr),
            .stat_hits  (stat_hits[g*STAT_W +: STAT_W]),
            .stat_miss  (stat_miss[g*STAT_W +: STAT_W])
        );
    end

endmodule

// File: tb/tb_stage5_field_extract.sv
// Directed and randomized bench for stage5_field_extract against a
// queue-based reference model (stats checks follow STAGE5_FIELD_STATS_EN).
module tb_stage5_field_extract;
    import stage5_field_extract_pkg::*;

    localparam int CH = 3;
    localparam int MW = MAX_MESSAGE_BITS;
    localparam int FW = FIELD_V4_BITS;
    localparam int CW = MESSAGE_MUX_CONTROL_WIDTH;
    localparam logic [FW-1:0] DEF = DEFAUT_INFOR;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              message_en;
    logic [CH-1:0]     in_valid;
    logic [CH-1:0]     in_ready;
    logic [CH*MW-1:0]  message;
    logic [CH*CW-1:0]  ctrl;
    logic [CH-1:0]     out_valid;
    logic [CH-1:0]     out_ready;
    logic [CH*FW-1:0]  out_field;
    logic [CH-1:0]     out_hit;
    logic              stats_clr;
    logic [CH*16-1:0]  stat_hits;
    logic [CH*16-1:0]  stat_miss;

    int errors = 0;
    int checks = 0;

    logic [FW:0] q [CH][$];
    int          m_hits [CH];
    int          m_miss [CH];
    int          pops [CH];

    always #5 clk = ~clk;

    stage5_field_extract dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .message_en          (message_en),
        .in_valid            (in_valid),
        .in_ready            (in_ready),
        .message             (message),
        .message_mux_control (ctrl),
        .out_valid           (out_valid),
        .out_ready           (out_ready),
        .out_field           (out_field),
        .out_hit             (out_hit),
        .stats_clr           (stats_clr),
        .stat_hits           (stat_hits),
        .stat_miss           (stat_miss)
    );

    task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Behavioural rule: disabled or unknown type gives the default, a miss.
    function automatic logic [FW:0] ref_fn(logic [MW-1:0] m, int t, logic en);
        logic [MW-1:0] s;
        if (!en) return {1'b0, DEF};
        if (t == 1) begin
            s = m >> A_V4_E;
            return {1'b1, s[FW-1:0]};
        end
        if (t == 2) begin
            s = m >> B_V4_E;
            return {1'b1, s[FW-1:0]};
        end
        return {1'b0, DEF};
    endfunction

    task automatic check_all(string tag);
        logic [FW:0] h;
        for (int i = 0; i < CH; i++) begin
            h = (q[i].size() != 0) ? q[i][0] : {1'b0, DEF};
            chk($sformatf("%s.in_ready%0d", tag, i), 64'(in_ready[i]),
                64'(q[i].size() < 2));
            chk($sformatf("%s.out_valid%0d", tag, i), 64'(out_valid[i]),
                64'(q[i].size() != 0));
            chk($sformatf("%s.field%0d", tag, i), 64'(out_field[i*FW +: FW]),
                64'(h[FW-1:0]));
            chk($sformatf("%s.hit%0d", tag, i), 64'(out_hit[i]), 64'(h[FW]));
            chk($sformatf("%s.shits%0d", tag, i), 64'(stat_hits[i*16 +: 16]),
                64'(m_hits[i]));
            chk($sformatf("%s.smiss%0d", tag, i), 64'(stat_miss[i*16 +: 16]),
                64'(m_miss[i]));
        end
    endtask

    task automatic cycle(string tag);
        logic        acc [CH];
        logic        pop [CH];
        logic [FW:0] hd;
        for (int i = 0; i < CH; i++) begin
            acc[i] = in_valid[i] && (q[i].size() < 2);
            pop[i] = out_ready[i] && (q[i].size() != 0);
            if (out_valid[i] && out_ready[i]) pops[i]++;
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < CH; i++) begin
            if (pop[i]) begin
                hd = q[i].pop_front();
`ifdef STAGE5_FIELD_STATS_EN
                if (!stats_clr) begin
                    if (hd[FW]) m_hits[i] = (m_hits[i] == 65535) ? 65535 : m_hits[i] + 1;
                    else        m_miss[i] = (m_miss[i] == 65535) ? 65535 : m_miss[i] + 1;
                end
`endif
            end
`ifdef STAGE5_FIELD_STATS_EN
            if (stats_clr) begin
                m_hits[i] = 0;
                m_miss[i] = 0;
            end
`endif
            if (acc[i])
                q[i].push_back(ref_fn(message[i*MW +: MW],
                                      int'(ctrl[i*CW +: CW]), message_en));
        end
        check_all(tag);
    endtask

    task automatic set_lane(int i, logic [MW-1:0] m, int t);
        message[i*MW +: MW] = m;
        ctrl[i*CW +: CW]    = CW'(t);
    endtask

    task automatic model_reset();
        for (int i = 0; i < CH; i++) begin
            q[i].delete();
            m_hits[i] = 0;
            m_miss[i] = 0;
        end
    endtask

    task automatic randomize_inputs();
        for (int i = 0; i < CH; i++)
            set_lane(i, {$urandom, $urandom, $urandom, $urandom},
                     int'($urandom_range(0, 3)));
    endtask

    initial begin
        logic [MW-1:0] m;
        int            exp_h;
        int            exp_m;

        rst_n      = 1'b0;
        message_en = 1'b1;
        in_valid   = '0;
        out_ready  = '0;
        message    = '0;
        ctrl       = '0;
        stats_clr  = 1'b0;
        model_reset();
        for (int i = 0; i < CH; i++) pops[i] = 0;
        repeat (3) @(posedge clk);
        #1;
        check_all("in_reset");
        rst_n = 1'b1;
        #1;
        check_all("reset");
        chk("reset.in_ready", 64'(in_ready), 64'(3'b111));

        // Lane 0, type a
        out_ready = '1;
        m = '0;
        m[A_V4_E +: FW] = 32'h1234_5678;
        set_lane(0, m, 1);
        in_valid = 3'b001;
        cycle("a0");
        chk("a0.field", 64'(out_field[0 +: FW]), 64'h1234_5678);
        chk("a0.hit", 64'(out_hit[0]), 64'd1);
        in_valid = '0;
        cycle("a0_drain");

        // Lane 1: type b, unknown, disabled
        m = '0;
        m[B_V4_E +: FW] = 32'hCAFE_0001;
        set_lane(1, m, 2);
        in_valid = 3'b010;
        cycle("b1");
        chk("b1.field", 64'(out_field[FW +: FW]), 64'hCAFE_0001);
        set_lane(1, m, 3);
        cycle("u1");
        chk("u1.field", 64'(out_field[FW +: FW]), 64'(DEF));
        chk("u1.hit", 64'(out_hit[1]), 64'd0);
        message_en = 1'b0;
        set_lane(1, m, 1);
        cycle("d1");
        chk("d1.hit", 64'(out_hit[1]), 64'd0);
        message_en = 1'b1;
        in_valid = '0;
        cycle("b1_drain");

        // Lane 2 backpressure
        out_ready = 3'b011;
        in_valid  = 3'b100;
        for (int k = 0; k < 3; k++) begin
            m = '0;
            m[A_V4_E +: FW] = 32'h0000_0A00 + 32'(k);
            set_lane(2, m, 1);
            cycle($sformatf("bp%0d", k));
        end
        chk("bp.in_ready_low", 64'(in_ready[2]), 64'd0);
        out_ready = 3'b111;
        cycle("bp_pop0");
        chk("bp.in_ready_rise", 64'(in_ready[2]), 64'd1);
        chk("bp.head1", 64'(out_field[2*FW +: FW]), 64'h0000_0A01);
        cycle("bp_push2");
        in_valid = '0;
        repeat (3) cycle("bp_drain");

        // Continuous streaming on all lanes
        for (int i = 0; i < CH; i++) pops[i] = 0;
        in_valid = '1;
        for (int k = 0; k < 100; k++) begin
            randomize_inputs();
            message_en = ($urandom_range(0, 7) != 0);
            cycle("stream");
        end
        in_valid = '0;
        cycle("stream_end");
        for (int i = 0; i < CH; i++)
            chk($sformatf("stream.pops%0d", i), 64'(pops[i]), 64'd100);

        // Random valid/ready
        for (int k = 0; k < 300; k++) begin
            randomize_inputs();
            in_valid   = CH'($urandom);
            out_ready  = CH'($urandom);
            message_en = ($urandom_range(0, 3) != 0);
            cycle("rand");
        end
        in_valid  = '0;
        out_ready = '1;
        repeat (3) cycle("rand_drain");

        // Asynchronous reset while lanes hold entries
        out_ready = '0;
        in_valid  = '1;
        randomize_inputs();
        repeat (2) cycle("fill");
        #3 rst_n = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        #1 rst_n = 1'b1;
        in_valid  = '0;
        out_ready = '1;
        cycle("post_rst");

        // Statistics: 3 hits then 2 misses on lane 0
        stats_clr = 1'b1;
        cycle("clr0");
        stats_clr = 1'b0;
        message_en = 1'b1;
        in_valid = 3'b001;
        for (int k = 0; k < 5; k++) begin
            m = {$urandom, $urandom, $urandom, $urandom};
            set_lane(0, m, (k == 0) ? 1 : (k < 3) ? 2 : 0);
            if (k == 4) begin
                set_lane(0, m, 1);
                message_en = 1'b0;
            end
            cycle("st_push");
        end
        message_en = 1'b1;
        in_valid = '0;
        repeat (2) cycle("st_drain");
`ifdef STAGE5_FIELD_STATS_EN
        exp_h = 3;
        exp_m = 2;
`else
        exp_h = 0;
        exp_m = 0;
`endif
        chk("st.hits", 64'(stat_hits[0 +: 16]), 64'(exp_h));
        chk("st.miss", 64'(stat_miss[0 +: 16]), 64'(exp_m));
        out_ready = '0;
        in_valid  = 3'b001;
        set_lane(0, m, 1);
        cycle("st_one");
        in_valid  = '0;
        out_ready = '1;
        stats_clr = 1'b1;
        cycle("st_clr_pop");
        stats_clr = 1'b0;
        chk("stclr.hits", 64'(stat_hits[0 +: 16]), 64'd0);
        chk("stclr.miss", 64'(stat_miss[0 +: 16]), 64'd0);
        cycle("end");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
